// File: rtl/fft_frame_gen_if.sv
// Sample stream between the frame generator and an FFT core.
// valid/ready: a sample transfers on a rising edge where valid & ready are both 1; while valid=1 and
// ready=0 the master holds data_real, data_img, start and over unchanged, and valid never depends on ready.
interface fft_frame_gen_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic             start;
  logic             over;
  logic [WIDTH-1:0] data_real;
  logic [WIDTH-1:0] data_img;

  modport master (
    output valid, start, over, data_real, data_img,
    input  ready
  );

  modport slave (
    input  valid, start, over, data_real, data_img,
    output ready
  );
endinterface

// File: rtl/fft_frame_gen.sv
// Frame source for the FFT cores: 2^LAYER-point complex frames with start/over framing,
// programmable frame count, inter-frame gap and four test patterns.
module fft_frame_gen #(
  parameter int WIDTH = 32,
  parameter int LAYER = 5,
  parameter int GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [7:0]  frames,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg,
  fft_frame_gen_if.master m
);

  // state_dbg carries this encoding directly (IDLE reads as 0).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LAYER-1:0] KMAX     = '1;
  localparam int               GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_n;
  logic [LAYER-1:0] k_q, k_n;
  logic [7:0]       cnt_q, cnt_n, cnt_inc;
  logic [GW-1:0]    gap_q, gap_n;
  logic [1:0]       mode_q, mode_n;
  logic [7:0]       frames_q, frames_n;
  logic             run_n;

  function automatic logic [2*WIDTH-1:0] pattern(input logic [1:0] md, input logic [LAYER-1:0] k);
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    re = '0;
    im = '0;
    case (md)
      2'd0: begin
        re = WIDTH'(k);
        im = WIDTH'(KMAX - k);
      end
      2'd1:    re = (k == '0) ? WIDTH'(1) : '0;
      2'd2:    re = WIDTH'(1);
      default: re = k[0] ? '1 : WIDTH'(1);
    endcase
    return {re, im};
  endfunction

  always_comb begin
    state_n  = state_q;
    k_n      = k_q;
    cnt_n    = cnt_q;
    gap_n    = gap_q;
    mode_n   = mode_q;
    frames_n = frames_q;
    cnt_inc  = cnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_n  = S_RUN;
          mode_n   = mode;
          frames_n = frames;
          k_n      = '0;
          cnt_n    = '0;
        end
      end
      S_RUN: begin
        if (m.ready) begin
          if (k_q != KMAX) begin
            k_n = k_q + 1'b1;
          end else begin
            // En is only consulted at a frame boundary, so a frame always completes.
            k_n   = '0;
            cnt_n = cnt_inc;
            if ((frames_q != 8'd0) && (cnt_inc == frames_q)) begin
              state_n = S_DONE;
            end else if (!en) begin
              state_n = S_DONE;
            end else if (GAP > 0) begin
              state_n = S_GAP;
              gap_n   = GAP_LOAD;
            end
          end
        end
      end
      S_GAP: begin
        if (!en) begin
          state_n = S_DONE;
        end else if (gap_q == '0) begin
          state_n = S_RUN;
        end else begin
          gap_n = gap_q - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    run_n = (state_n == S_RUN);
  end

  // Outputs are registered from the next-state values, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      mode_q      <= '0;
      frames_q    <= '0;
      m.valid     <= 1'b0;
      m.start     <= 1'b0;
      m.over      <= 1'b0;
      m.data_real <= '0;
      m.data_img  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      k_q         <= k_n;
      cnt_q       <= cnt_n;
      gap_q       <= gap_n;
      mode_q      <= mode_n;
      frames_q    <= frames_n;
      m.valid     <= run_n;
      m.start     <= run_n && (k_n == '0);
      m.over      <= run_n && (k_n == KMAX);
      {m.data_real, m.data_img} <= run_n ? pattern(mode_n, k_n) : '0;
      busy        <= (state_n == S_RUN) || (state_n == S_GAP);
      done        <= (state_n == S_DONE);
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_fft_frame_gen.sv
// Self-checking bench for fft_frame_gen: directed runs plus a randomized run, checked against a
// frame-level reference queue built from the pattern rules.
module tb_fft_frame_gen;
  localparam int WIDTH = 32;
  localparam int LAYER = 5;
  localparam int GAP   = 2;
  localparam int N     = 1 << LAYER;

  typedef logic [2*WIDTH+1:0] smp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] frames = 8'd0;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  fft_frame_gen_if #(.WIDTH(WIDTH)) bus ();

  fft_frame_gen #(.WIDTH(WIDTH), .LAYER(LAYER), .GAP(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .frames(frames),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg),
    .m(bus)
  );

  always #5 clk = ~clk;

  smp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic smp_t ref_sample(input int md, input int k);
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    re = '0;
    im = '0;
    case (md)
      0: begin
        re = WIDTH'(k);
        im = WIDTH'(N - 1 - k);
      end
      1: re = (k == 0) ? WIDTH'(1) : '0;
      2: re = WIDTH'(1);
      default: re = (k % 2 == 0) ? WIDTH'(1) : {WIDTH{1'b1}};
    endcase
    return {re, im, (k == 0), (k == N - 1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_start_over"}, {bus.start, bus.over}, 0);
    chk({tag, "_data"}, {bus.data_real, bus.data_img}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // rp: 0 ready always 1, 1 ready cycles 1,0,0,1, 2 random ready.
  // drop_f/drop_k: drop en on accepting sample drop_k of frame drop_f (0-based), -1 = never.
  // rst_k: pull reset while sample rst_k of the first frame is shown, -1 = never.
  task automatic run(input int md, input int nfr, input int rp, input int drop_f, input int drop_k,
                     input int rst_k, input int exp_frames);
    int   cyc;
    int   frm;
    int   kk;
    int   idle;
    int   pat;
    bit   fin;
    bit   got_done;
    bit   have_held;
    bit   in_gap;
    bit   last_acc;
    bit   r;
    smp_t held;
    smp_t obs;
    smp_t e;
    exp_q.delete();
    for (int f = 0; f < exp_frames; f++)
      for (int k = 0; k < N; k++) exp_q.push_back(ref_sample(md, k));
    @(negedge clk);
    en = 1'b1;
    mode = 2'(md);
    frames = 8'(nfr);
    bus.ready = 1'b0;
    cyc = 0; frm = 0; kk = 0; idle = 0; pat = 0;
    fin = 0; got_done = 0; have_held = 0; in_gap = 0; last_acc = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      obs = {bus.data_real, bus.data_img, bus.start, bus.over};
      if (cyc == 1) begin
        chk("start_latency", {bus.valid, bus.start}, 2'b11);
        mode = 2'(md) ^ 2'd1;
        frames = 8'($urandom_range(1, 255));
      end
      if (rst_k >= 0 && bus.valid && frm == 0 && kk == rst_k) begin
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check_quiet("reset_mid");
        chk("reset_state_idle", state_dbg, 0);
        @(negedge clk);
        chk("reset_no_done", done, 0);
        rst = 1'b1;
        exp_q.delete();
        fin = 1;
      end else if (done) begin
        got_done = 1;
        fin = 1;
        chk("done_after_last_accept", last_acc, 1);
        chk("done_queue_empty", 64'(exp_q.size()), 0);
        chk("done_busy_low", busy, 0);
        chk("done_valid_low", bus.valid, 0);
        en = 1'b0;
      end else begin
        chk("busy_high", busy, 1);
        if (have_held) begin
          chk("hold_valid", bus.valid, 1);
          chk("hold_stable", obs, held);
        end
        if (bus.valid) begin
          if (in_gap) begin
            chk("gap_length", 64'(idle), 64'(GAP));
            in_gap = 0;
          end
          case (rp)
            0: r = 1'b1;
            1: r = (pat % 4 == 0) || (pat % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
          endcase
          pat++;
          bus.ready = r;
          if (r) begin
            have_held = 0;
            last_acc = 1;
            chk("extra_sample", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("data_real", bus.data_real, e[2*WIDTH+1:WIDTH+2]);
              chk("data_img", bus.data_img, e[WIDTH+1:2]);
              chk("start_over", {bus.start, bus.over}, e[1:0]);
            end
            if (frm == drop_f && kk == drop_k) en = 1'b0;
            if (kk == N - 1) begin
              kk = 0;
              frm++;
              in_gap = 1;
              idle = 0;
            end else begin
              kk++;
            end
          end else begin
            have_held = 1;
            held = obs;
            last_acc = 0;
          end
        end else begin
          have_held = 0;
          idle++;
          last_acc = 0;
          bus.ready = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (got_done) begin
      @(negedge clk);
      check_quiet("after_done");
    end
    en = 1'b0;
  endtask

  initial begin
    bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    chk("reset_state_idle", state_dbg, 0);
    rst = 1'b1;

    // One ramp frame, ready always high.
    run(0, 1, 0, -1, -1, -1, 1);
    // Three impulse frames with the two-cycle gap between them.
    run(1, 3, 0, -1, -1, -1, 3);
    // Nyquist under a 1,0,0,1 ready pattern.
    run(3, 2, 1, -1, -1, -1, 2);
    // Continuous DC, en dropped at k=10 of frame 2: frame 2 completes, no frame 3.
    run(2, 0, 0, 1, 10, -1, 2);
    // Reset at k=17 mid-frame, then a fresh ramp frame.
    run(0, 0, 0, -1, -1, 17, 1);
    run(0, 1, 0, -1, -1, -1, 1);
    // Randomized pattern, count and ready.
    begin
      int md;
      int nfr;
      md  = $urandom_range(0, 3);
      nfr = $urandom_range(1, 3);
      run(md, nfr, 2, -1, -1, -1, nfr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
